// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package rv_fetch_pkg;

   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned INSTR_W_DEF  = 32;
   localparam logic [7:0]  RESET_PC_DEF = 8'h00;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_VALID = 3'd2,
      S_DROP  = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_e;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural PC register with load enable; resets to RESET_PC.
module pc_reg
   import rv_fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc_out
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = load_en ? pc_in : pc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_out = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and hands one
// instruction at a time to decode over valid/ready.
//
// state   | meaning
// S_REQ   | request cycle at pc (or request set-up right after reset)
// S_WAIT  | request outstanding, waiting for imem_ack
// S_VALID | instruction buffered and offered to decode
// S_DROP  | redirected while a request was outstanding; discard its data
// S_HALT  | misaligned pc seen; quiescent until reset
module pc_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = ADDR_W_DEF,
   parameter int unsigned        INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  next_pc,
   input  logic               flush,
   output logic [ADDR_W-1:0]  pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               id_ready,
   output logic               fetch_err
);

   fetch_state_e        state_q, state_d;
   logic                imem_req_q, imem_req_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic                if_valid_q, if_valid_d;
   logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
   logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
   logic                fetch_err_q, fetch_err_d;
   logic                pc_load;
   logic [ADDR_W-1:0]   pc_q;
   logic                launch;
   logic [ADDR_W-1:0]   launch_pc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (pc_load),
      .pc_in   (next_pc),
      .pc_out  (pc_q)
   );

   always_comb begin
      state_d     = state_q;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      fetch_err_d = fetch_err_q;
      pc_load     = 1'b0;
      launch      = 1'b0;
      launch_pc   = pc_q;

      case (state_q)
         S_REQ, S_WAIT: begin
            if (flush) begin
               pc_load = 1'b1;
               // an issued request cannot be withdrawn; wait out its ack
               if (imem_req_q && !imem_ack) begin
                  state_d = S_DROP;
               end else begin
                  launch    = 1'b1;
                  launch_pc = next_pc;
               end
            end else if (!is_aligned(pc_q[1:0])) begin
               fetch_err_d = 1'b1;
               imem_req_d  = 1'b0;
               state_d     = S_HALT;
            end else if (!imem_req_q) begin
               launch    = 1'b1;
               launch_pc = pc_q;
            end else if (imem_ack) begin
               if_instr_d = imem_rdata;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               imem_req_d = 1'b0;
               state_d    = S_VALID;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_VALID: begin
            if (flush || id_ready) begin
               if_valid_d = 1'b0;
               pc_load    = 1'b1;
               launch     = 1'b1;
               launch_pc  = next_pc;
            end
         end
         S_DROP: begin
            if (flush) pc_load = 1'b1;
            if (imem_ack) begin
               launch    = 1'b1;
               launch_pc = flush ? next_pc : pc_q;
            end
         end
         S_HALT: begin
         end
         default: state_d = S_REQ;
      endcase

      // a misaligned target enters S_REQ without raising imem_req
      if (launch) begin
         state_d     = S_REQ;
         imem_req_d  = is_aligned(launch_pc[1:0]);
         imem_addr_d = launch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
         if_valid_q  <= 1'b0;
         if_instr_q  <= '0;
         if_pc_q     <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign pc        = pc_q;
   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then randomized traffic against
// a transaction-level model (architectural pc, mem[a]=0x100+a, handshake rules).
module tb_pc_fetch_unit;
   import rv_fetch_pkg::*;

   localparam int unsigned    AW  = 8;
   localparam int unsigned    IW  = 32;
   localparam logic [AW-1:0]  RPC = 8'h00;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] next_pc;
   logic          flush;
   logic [AW-1:0] pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic          if_valid;
   logic [IW-1:0] if_instr;
   logic [AW-1:0] if_pc;
   logic          id_ready;
   logic          fetch_err;

   always #5 clk = ~clk;

   pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .next_pc    (next_pc),
      .flush      (flush),
      .pc         (pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .id_ready   (id_ready),
      .fetch_err  (fetch_err)
   );

   int            checks   = 0;
   int            failures = 0;
   int            cycles   = 0;
   logic [AW-1:0] exp_pc;
   bit            m_halted;
   bit            rand_lat;
   int            lat;
   int            wait_cnt;
   logic [AW-1:0] deliv_pc[$];
   int            deliv_cyc[$];

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'h100 + 32'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_mem();
      imem_ack   = imem_req && (wait_cnt >= lat);
      imem_rdata = imem_ack ? mem_word(imem_addr) : IW'($urandom);
   endtask

   // One clock: model bookkeeping before the edge, checks 1 time unit after it.
   task automatic tick();
      bit            stall, pend, hs, was_req;
      logic [AW-1:0] h_pc, h_addr, new_pc;
      logic [IW-1:0] h_instr;
      new_pc = exp_pc;
      if (if_valid && id_ready && !flush) begin
         chk("deliver_pc", 32'(if_pc), 32'(exp_pc));
         chk("deliver_instr", if_instr, mem_word(exp_pc));
         deliv_pc.push_back(if_pc);
         deliv_cyc.push_back(cycles);
      end
      if (!m_halted && (flush || (if_valid && id_ready))) new_pc = next_pc;
      stall   = if_valid && !id_ready && !flush;
      pend    = imem_req && !imem_ack;
      hs      = imem_req && imem_ack;
      was_req = imem_req;
      h_pc    = if_pc;
      h_instr = if_instr;
      h_addr  = imem_addr;
      @(posedge clk);
      #1;
      cycles++;
      exp_pc = new_pc;
      chk("pc", 32'(pc), 32'(exp_pc));
      chk("req_with_valid", 32'(imem_req && if_valid), 32'd0);
      if (stall) begin
         chk("stall_valid", 32'(if_valid), 32'd1);
         chk("stall_if_pc", 32'(if_pc), 32'(h_pc));
         chk("stall_instr", if_instr, h_instr);
      end
      if (pend) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_held", 32'(imem_addr), 32'(h_addr));
      end
      if (hs || !was_req) begin
         wait_cnt = 0;
         if (rand_lat) lat = int'($urandom_range(0, 3));
      end else begin
         wait_cnt++;
      end
      drive_mem();
      flush   = 1'b0;
      next_pc = pc + 8'd4;
   endtask

   task automatic model_init();
      exp_pc   = RPC;
      m_halted = 1'b0;
      wait_cnt = 0;
      lat      = 0;
      rand_lat = 1'b0;
      deliv_pc.delete();
      deliv_cyc.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      flush      = 1'b0;
      id_ready   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      next_pc    = '0;
      #1;
      chk("rst_pc", 32'(pc), 32'(RPC));
      chk("rst_addr", 32'(imem_addr), 32'(RPC));
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_if_pc", 32'(if_pc), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_init();
      next_pc = pc + 8'd4;
   endtask

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      id_ready   = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      next_pc    = '0;
      model_init();

      // 1: zero-wait memory, sequential stream
      apply_reset();
      id_ready = 1'b1;
      for (int i = 0; i < 12 && deliv_pc.size() < 3; i++) tick();
      chk("t1_count", 32'(deliv_pc.size()), 32'd3);
      if (deliv_pc.size() >= 3) begin
         chk("t1_pc0", 32'(deliv_pc[0]), 32'h00);
         chk("t1_pc1", 32'(deliv_pc[1]), 32'h04);
         chk("t1_pc2", 32'(deliv_pc[2]), 32'h08);
         chk("t1_gap01", 32'(deliv_cyc[1] - deliv_cyc[0]), 32'd2);
         chk("t1_gap12", 32'(deliv_cyc[2] - deliv_cyc[1]), 32'd2);
      end

      // 2: three-cycle ack latency at 0x10
      id_ready = 1'b0;
      tick();
      chk("t2_valid_0c", 32'(if_valid), 32'd1);
      chk("t2_if_pc_0c", 32'(if_pc), 32'h0C);
      lat      = 2;
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_req", 32'(imem_req), 32'd1);
         chk("t2_addr", 32'(imem_addr), 32'h10);
         chk("t2_not_valid", 32'(if_valid), 32'd0);
         tick();
      end
      chk("t2_valid", 32'(if_valid), 32'd1);
      chk("t2_if_pc", 32'(if_pc), 32'h10);

      // 3: backpressure for 5 cycles
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t3_valid", 32'(if_valid), 32'd1);
         chk("t3_if_pc", 32'(if_pc), 32'h10);
         chk("t3_instr", if_instr, 32'h110);
         chk("t3_pc", 32'(pc), 32'h10);
         chk("t3_no_req", 32'(imem_req), 32'd0);
      end

      // 4: flush while waiting; stale data must be dropped
      lat      = 3;
      id_ready = 1'b1;
      tick();
      chk("t4_addr14", 32'(imem_addr), 32'h14);
      tick();
      flush   = 1'b1;
      next_pc = 8'h40;
      tick();
      chk("t4_pc40", 32'(pc), 32'h40);
      chk("t4_req_kept", 32'(imem_req), 32'd1);
      chk("t4_addr_old", 32'(imem_addr), 32'h14);
      tick();
      chk("t4_addr_old2", 32'(imem_addr), 32'h14);
      chk("t4_no_valid", 32'(if_valid), 32'd0);
      lat = 0;
      tick();
      chk("t4_req_new", 32'(imem_req), 32'd1);
      chk("t4_addr_new", 32'(imem_addr), 32'h40);
      chk("t4_no_valid2", 32'(if_valid), 32'd0);
      tick();
      chk("t4_valid", 32'(if_valid), 32'd1);
      chk("t4_if_pc", 32'(if_pc), 32'h40);
      chk("t4_instr", if_instr, 32'h140);

      // 5: wrap 0xFC -> 0x00, then misaligned target halts
      flush   = 1'b1;
      next_pc = 8'hFC;
      tick();
      chk("t5_addr_fc", 32'(imem_addr), 32'hFC);
      tick();
      chk("t5_if_pc_fc", 32'(if_pc), 32'hFC);
      tick();
      chk("t5_wrap_addr", 32'(imem_addr), 32'h00);
      chk("t5_wrap_req", 32'(imem_req), 32'd1);
      tick();
      chk("t5_if_pc_00", 32'(if_pc), 32'h00);
      next_pc = 8'h06;
      tick();
      chk("t5_no_req", 32'(imem_req), 32'd0);
      chk("t5_err_pre", 32'(fetch_err), 32'd0);
      tick();
      chk("t5_err", 32'(fetch_err), 32'd1);
      chk("t5_halt_req", 32'(imem_req), 32'd0);
      chk("t5_halt_valid", 32'(if_valid), 32'd0);
      m_halted = 1'b1;
      flush    = 1'b1;
      next_pc  = 8'h20;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_halt_pc", 32'(pc), 32'h06);
         chk("t5_halt_err", 32'(fetch_err), 32'd1);
         chk("t5_halt_req2", 32'(imem_req), 32'd0);
      end

      // 6: reset asserted while waiting; stale ack ignored afterwards
      apply_reset();
      lat      = 5;
      id_ready = 1'b1;
      tick();
      chk("t6_req", 32'(imem_req), 32'd1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(imem_req), 32'd0);
      chk("t6_rst_pc", 32'(pc), 32'(RPC));
      chk("t6_rst_addr", 32'(imem_addr), 32'(RPC));
      imem_ack   = 1'b1;
      imem_rdata = NOP_INSTR;
      @(negedge clk);
      rst_n = 1'b1;
      model_init();
      @(posedge clk);
      #1;
      cycles++;
      chk("t6_setup_req", 32'(imem_req), 32'd1);
      chk("t6_setup_addr", 32'(imem_addr), 32'(RPC));
      chk("t6_stale_ignored", 32'(if_valid), 32'd0);
      drive_mem();
      flush   = 1'b0;
      next_pc = pc + 8'd4;
      tick();
      chk("t6_valid", 32'(if_valid), 32'd1);
      chk("t6_if_pc", 32'(if_pc), 32'(RPC));
      chk("t6_instr", if_instr, mem_word(RPC));

      // randomized traffic: latency, backpressure, redirects
      rand_lat = 1'b1;
      deliv_pc.delete();
      deliv_cyc.delete();
      for (int i = 0; i < 800; i++) begin
         id_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            flush   = 1'b1;
            next_pc = AW'($urandom_range(0, 63)) << 2;
         end
         tick();
      end
      chk("rand_progress", 32'(deliv_pc.size() >= 30), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage wrapped around the next-PC adder.
- Holds the architectural PC register and drives `pc` to the adder; consumes the adder's `address_out` as `next_pc`.
- Fetches from instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode over a valid/ready handshake.

Parameters:
- ADDR_W, 8: PC and instruction-memory address width.
- INSTR_W, 32: instruction width.
- RESET_PC, 8'h00: PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- next_pc  input  ADDR_W  next PC from the next-PC adder (`address_out`).
- flush  input  1  redirect: discard the current or in-flight instruction and load PC from next_pc.
- pc  output  ADDR_W  current PC register, fed to the next-PC adder's `address` input.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address, stable while imem_req is high.
- imem_ack  input  1  memory has returned data; may arrive in the same cycle as the request or later.
- imem_rdata  input  INSTR_W  instruction data, valid when imem_ack is high.
- if_valid  output  1  instruction available to decode.
- if_instr  output  INSTR_W  buffered instruction.
- if_pc  output  ADDR_W  PC of if_instr.
- id_ready  input  1  decode accepts the instruction.
- fetch_err  output  1  misaligned PC detected; sticky until reset.

Behaviour:
- Reset values (async, while rst_n=0):
  - pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
  - FSM = S_REQ.
  - Outputs drop immediately on reset assertion, including mid-transaction; any pending memory ack after reset release is ignored because the FSM restarts in S_REQ.
- FSM states: S_REQ, S_WAIT, S_VALID, S_DROP, S_HALT. All outputs are registered.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - If pc[1:0]!=0: set fetch_err=1, deassert imem_req, go to S_HALT. No request is issued.
  - Else if imem_ack: capture imem_rdata into if_instr and pc into if_pc, go to S_VALID.
  - Else go to S_WAIT.
- S_WAIT:
  - imem_req held at 1; imem_addr is unchanged.
  - On imem_ack: capture data as in S_REQ, go to S_VALID.
- S_VALID:
  - if_valid=1; imem_req=0.
  - On if_valid && id_ready: pc<=next_pc, go to S_REQ.
  - If id_ready=0: if_instr and if_pc hold stable.
- flush, highest priority over all other transitions:
  - S_VALID: if_valid<=0, pc<=next_pc, go to S_REQ. The instruction is not delivered.
  - S_REQ or S_WAIT with imem_ack=1 in that cycle: discard the data, pc<=next_pc, go to S_REQ.
  - S_REQ or S_WAIT with imem_ack=0: pc<=next_pc, go to S_DROP. imem_req stays high and imem_addr keeps the old address (the protocol forbids withdrawing a request).
  - S_DROP: on imem_ack, discard the data and go to S_REQ, where a new request is issued at the current pc.
  - A further flush while in S_DROP updates pc only.
  - flush in S_HALT is ignored.
- S_HALT: all outputs quiescent except fetch_err=1; exit only via reset.
- Latency and throughput:
  - With zero-wait memory (ack in the request cycle), an instruction is presented 1 cycle after the PC update.
  - Peak throughput is 1 instruction per 2 cycles.
  - Each memory wait cycle adds one cycle.
- Arithmetic and width rules:
  - next_pc is taken verbatim; the PC wraps modulo 2^ADDR_W (0xFC+4 -> 0x00 is legal).
  - No internal adder.
- pc changes only on accept or flush, so next_pc from the combinational adder is sampled only at those edges.

Decomposition:
- Shared package (rv_fetch_pkg):
  - state typedef (S_REQ, S_WAIT, S_VALID, S_DROP, S_HALT);
  - ADDR_W and INSTR_W defaults;
  - RESET_PC;
  - NOP encoding 32'h00000013 for bench use.
- Optional sub-module: pc_reg (ADDR_W register, async active-low reset to RESET_PC, load enable). The FSM and buffer stay in pc_fetch_unit.

Test Plan:
1. Zero-wait memory returning mem[a]=0x100+a; next_pc=pc+4; id_ready=1 -> accepted if_pc sequence 0x00,0x04,0x08, one accept every 2 cycles; if_instr=0x100,0x104,0x108.
2. Memory with 3-cycle ack latency -> imem_req held 3 cycles with imem_addr constant; if_valid rises the cycle after ack.
3. Backpressure: id_ready=0 for 5 cycles in S_VALID -> if_instr and if_pc stable; pc unchanged; no imem_req.
4. flush in S_WAIT with next_pc=0x40, ack 2 cycles later -> the old data is never presented; the next request has imem_addr=0x40; first delivered if_pc=0x40.
5. Wrap and misalign: pc=0xFC, next_pc=0x00 -> next fetch at 0x00. Then next_pc=0x06 -> fetch_err=1, imem_req=0, FSM stays in S_HALT.
6. Assert rst_n=0 mid-S_WAIT -> imem_req=0 immediately; after release the first fetch is at RESET_PC and the stale ack is ignored.
